// File: rtl/agex_muldiv_seq_pkg.sv
// Op/state encodings and op-decode helpers for the AGEX mul/div sequencer.
// Purely declarative: no latency or flow control of its own.
package agex_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_BUSY = 2'd1,
    MD_ST_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_want_hi(input logic [2:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  function automatic logic md_want_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_signed_a(input logic [2:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/agex_muldiv_seq_iter_dp.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per cycle on unsigned magnitudes.
// Latency is one cycle per step; no flow control, the sequencer drives load/step.
module agex_muldiv_seq_iter_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Remainder stays below the divisor, so the XLEN+1-bit trial's top bit is a true sign.
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
    shifted = {hi_q, lo_q[XLEN-1]};
    trial   = shifted - {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= a;
      b_q  <= b;
    end else if (step) begin
      if (is_div) begin
        hi_q <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], ~trial[XLEN]};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/agex_muldiv_seq.sv
// AGEX mul/div sequencer: result_valid XLEN+1 cycles after start; stall_out holds the pipeline until then.
// Signed ops (MULH/MULHSU/DIV/REM) only when MULDIV_SIGNED_EN is defined; otherwise mapped to unsigned.
module agex_muldiv_seq
  import agex_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall_out,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] result_q;
  logic            dp_load, dp_step;
  logic [XLEN-1:0] a_acc, b_acc;
  logic [XLEN-1:0] dp_hi, dp_lo;
  logic [XLEN-1:0] fix_res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MD_ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    stall_out    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    dp_load      = 1'b0;
    dp_step      = 1'b0;
    case (state_q)
      MD_ST_IDLE: begin
        // Combinational stall keeps the op in AGEX on the accept edge.
        stall_out = start & ~flush & reset_n;
        if (start && !flush) begin
          dp_load = 1'b1;
          state_d = MD_ST_BUSY;
        end
      end
      MD_ST_BUSY: begin
        stall_out = 1'b1;
        busy      = 1'b1;
        if (flush) begin
          state_d = MD_ST_IDLE;
        end else begin
          dp_step = 1'b1;
          if (cnt_q == '0) state_d = MD_ST_DONE;
        end
      end
      MD_ST_DONE: begin
        result_valid = 1'b1;
        state_d      = MD_ST_IDLE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      if (dp_load) begin
        cnt_q <= CNT_W'(XLEN - 1);
        op_q  <= op;
      end else if (dp_step) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (result_valid) result_q <= fix_res;
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic                a_sgn, b_sgn, neg_acc, neg_q;
  logic [2*XLEN-1:0]   prod, prod_fix;
  logic [XLEN-1:0]     div_raw, div_fix;

  // Divide by zero already yields all-ones quotient / dividend remainder, so only the remainder sign applies.
  always_comb begin
    a_sgn = md_signed_a(op) & rs1_val[XLEN-1];
    b_sgn = md_signed_b(op) & rs2_val[XLEN-1];
    a_acc = a_sgn ? -rs1_val : rs1_val;
    b_acc = b_sgn ? -rs2_val : rs2_val;
    if (md_is_div(op))
      neg_acc = md_want_rem(op) ? a_sgn : ((a_sgn ^ b_sgn) & (rs2_val != '0));
    else
      neg_acc = a_sgn ^ b_sgn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     neg_q <= 1'b0;
    else if (dp_load) neg_q <= neg_acc;
  end

  always_comb begin
    prod     = {dp_hi, dp_lo};
    prod_fix = neg_q ? -prod : prod;
    div_raw  = md_want_rem(op_q) ? dp_hi : dp_lo;
    div_fix  = neg_q ? -div_raw : div_raw;
    if (md_is_div(op_q))
      fix_res = div_fix;
    else
      fix_res = md_want_hi(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end
`else
  always_comb begin
    a_acc = rs1_val;
    b_acc = rs2_val;
    if (md_is_div(op_q))
      fix_res = md_want_rem(op_q) ? dp_hi : dp_lo;
    else
      fix_res = md_want_hi(op_q) ? dp_hi : dp_lo;
  end
`endif

  agex_muldiv_seq_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (dp_load),
    .step    (dp_step),
    .is_div  (md_is_div(op_q)),
    .a       (a_acc),
    .b       (b_acc),
    .hi      (dp_hi),
    .lo      (dp_lo)
  );

  // Result is live during the DONE pulse and held afterwards.
  assign result = (state_q == MD_ST_DONE) ? fix_res : result_q;

endmodule

// File: tb/tb_agex_muldiv_seq.sv
// Directed bench for agex_muldiv_seq with an expected-result queue filled at issue and drained on result_valid.
module tb_agex_muldiv_seq;
  import agex_muldiv_seq_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            flush;
  logic            stall_out, result_valid, busy;
  logic [XLEN-1:0] result;

  int vectors     = 0;
  int miscompares = 0;
  logic [XLEN-1:0] exp_q[$];

  agex_muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .flush        (flush),
    .stall_out    (stall_out),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [63:0] up;
    logic [63:0] sv;
    longint      sp;
    int          sa, sb;
    up = {32'b0, a} * {32'b0, b};
    sa = a;
    sb = b;
    sp = 0;
`ifdef MULDIV_SIGNED_EN
    case (o)
      MD_OP_MUL:    return up[31:0];
      MD_OP_MULH:   begin sp = longint'(sa) * longint'(sb); sv = sp; return sv[63:32]; end
      MD_OP_MULHSU: begin sp = longint'(sa) * longint'({32'b0, b}); sv = sp; return sv[63:32]; end
      MD_OP_MULHU:  return up[63:32];
      MD_OP_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      MD_OP_DIVU:   return (b == 0) ? '1 : a / b;
      MD_OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return sa % sb;
      end
      default:      return (b == 0) ? a : a % b;
    endcase
`else
    sv = up;
    if (sp != 0 || sa != sb) sv = up;
    case (o)
      MD_OP_MUL:                              return sv[31:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU:  return sv[63:32];
      MD_OP_DIV, MD_OP_DIVU:                  return (b == 0) ? '1 : a / b;
      default:                                return (b == 0) ? a : a % b;
    endcase
`endif
  endfunction

  task automatic do_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    logic [XLEN-1:0] expv;
    int  stalls, lat;
    bit  got;
    exp_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1_val = a; rs2_val = b;
    stalls = 0; lat = -1; got = 1'b0;
    expv = '0;
    for (int c = 0; c < XLEN + 6 && !got; c++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        lat = c;
        check({tag, " stall_at_done"}, 32'(stall_out), 32'd0);
        expv = exp_q.pop_front();
        check({tag, " result"}, result, expv);
      end else if (stall_out) begin
        stalls++;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        rs1_val = $urandom;
        rs2_val = $urandom;
      end
    end
    start = 1'b0;
    if (!got) expv = exp_q.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(XLEN + 1));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(XLEN + 1));
    @(negedge clk);
    check({tag, " hold"}, result, expv);
    check({tag, " valid_pulse"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1_val = '0; rs2_val = '0;
    #1;
    check("rst stall_out", 32'(stall_out), 32'd0);
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op("mul_7x6",      MD_OP_MUL,   32'd7, 32'd6);
    do_op("mulhu_max",    MD_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("divu_100_7",   MD_OP_DIVU,  32'd100, 32'd7);
    do_op("remu_100_7",   MD_OP_REMU,  32'd100, 32'd7);
    do_op("divu_5_0",     MD_OP_DIVU,  32'd5, 32'd0);
    do_op("remu_5_0",     MD_OP_REMU,  32'd5, 32'd0);
    do_op("mul_zero",     MD_OP_MUL,   32'd0, 32'h1234_5678);
    do_op("mulhu_carry",  MD_OP_MULHU, 32'h8000_0000, 32'd2);
    do_op("divu_max_1",   MD_OP_DIVU,  32'hFFFF_FFFF, 32'd1);
    do_op("remu_pat",     MD_OP_REMU,  32'h1234_5678, 32'h0000_0010);

    // flush mid-BUSY
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_MUL; rs1_val = 32'd11; rs2_val = 32'd13;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    check("flush busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy_after", 32'(busy), 32'd0);
    check("flush stall_after", 32'(stall_out), 32'd0);
    pulses = 0;
    for (int c = 0; c < XLEN + 4; c++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("flush no_result", 32'(pulses), 32'd0);
    do_op("after_flush", MD_OP_MUL, 32'd12, 32'd12);

    // flush in IDLE suppresses start
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = MD_OP_MUL; rs1_val = 32'd2; rs2_val = 32'd2;
    @(negedge clk);
    check("idle_flush stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush busy", 32'(busy), 32'd0);

    // asynchronous reset mid-BUSY
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_MUL; rs1_val = 32'd5; rs2_val = 32'd5;
    repeat (8) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst stall_out", 32'(stall_out), 32'd0);
    check("arst result_valid", 32'(result_valid), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_op("mul_3x3_after_rst", MD_OP_MUL, 32'd3, 32'd3);

    do_op("div_ovf",      MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_m7_2",     MD_OP_REM,    32'hFFFF_FFF9, 32'd2);
    do_op("mulh_m1_m1",   MD_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu_m1_2",  MD_OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
    do_op("div_m7_2",     MD_OP_DIV,    32'hFFFF_FFF9, 32'd2);
    do_op("rem_m5_0",     MD_OP_REM,    32'hFFFF_FFFB, 32'd0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
